mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the RV32 core, sitting between EX and WB. It accepts one instruction at a time from EX and performs loads and stores on the data bus. It aligns store data, sign- or zero-extends load data, and detects misaligned accesses. Results are registered onto the MEM->WB pipeline interface, which WB consumes. A trap taken in WB kills the instruction in MEM, including draining any outstanding bus response.

## Interface
- SUPPORT_TRAP, 1: enables misaligned-access exception generation; when 0, low address bits are ignored.
- clk  in  1  core clock
- rst_b  in  1  asynchronous reset, active-high (rst_b=1 resets)
- mem_pipe_ready  out  1  MEM accepts the current EX->MEM entry this cycle
- mem_pipe_flush  out  1  kill upstream stages; equals wb_trap
- mem_pipe_valid  in  1  EX->MEM entry valid
- mem_pipe_{pc,instruction,rd_write,rd_addr,csr_write,csr_set,csr_clear,csr_read,csr_info,csr_addr,mret,exc_pending,exc_code,exc_tval,exc_interrupt}  in  as WB  passed through to wb_pipe_*
- mem_pipe_rd_data  in  XLEN  ALU result; this is the effective address for loads and stores
- mem_pipe_mem_read / mem_pipe_mem_write  in  1  load / store
- mem_pipe_mem_funct3  in  3  access width and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_pipe_mem_wdata  in  XLEN  store data (rs2)
- dbus_req  out  1  bus request
- dbus_write  out  1  1 = store
- dbus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata  out  XLEN  lane-replicated store data
- dbus_byte_enable  out  4  byte lanes
- dbus_ready  in  1  request accepted this cycle
- dbus_rvalid  in  1  load data valid
- dbus_rdata  in  XLEN  load data
- wb_pipe_ready  in  1  WB accepts the output register
- wb_trap  in  1  WB takes a trap this cycle
- wb_pipe_* (valid, pc, instruction, rd_write, rd_addr, rd_data, csr_*, mret, exc_*)  out  MEM->WB interface, registered

## Operation
- Finite state machine (FSM) states: IDLE, REQ, WAIT, HOLD, DRAIN.
- Memory op: mem_pipe_valid & (mem_read|mem_write) & ~mem_pipe_exc_pending & ~misaligned. Any other valid entry is "done" immediately in IDLE.
- Misaligned: an H access with addr[0]=1, or a W access with addr[1:0]≠0. No bus request is issued. Sets exc_pending=1, exc_code=4 (load) or 6 (store), exc_tval=addr.
- A pending upstream exception passes through unchanged, and no bus request is issued.
- IDLE: a memory op with ~wb_trap drives dbus_req combinationally.
  - Store with dbus_ready: done.
  - Load with dbus_ready: go to WAIT.
  - ~dbus_ready: go to REQ.
- REQ: holds dbus_req with a stable request.
  - On dbus_ready: a store is done; a load goes to WAIT.
- WAIT: on dbus_rvalid the load is done.
  - If the output register is not free, capture formatted data into the hold register and go to HOLD.
- HOLD: when the output register is free, write it and go to IDLE.
- Output register is free when ~wb_pipe_valid | wb_pipe_ready. mem_pipe_ready = done & free & ~wb_trap.
- Store formatting:
  - B: byte_enable=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H: byte_enable=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - W: byte_enable=1111.
- Load formatting: select the byte or half lane by addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU. The result replaces rd_data.
- Kill (wb_trap=1):
  - wb_pipe_valid clears at the next edge.
  - dbus_req is gated low in the same cycle.
  - IDLE/REQ/HOLD go to IDLE; the request is withdrawn and the store is not performed.
  - WAIT goes to DRAIN if rvalid has not yet arrived.
- DRAIN: discard the next dbus_rvalid, then go to IDLE. mem_pipe_ready=0 throughout.

## Timing
- Reset: state=IDLE; wb_pipe_valid=0; all wb_pipe_* fields=0; dbus_req=0; hold register=0.
- Non-memory instruction or accepted store: wb_pipe_valid one cycle after mem_pipe_valid.
- Load: dbus_rvalid no earlier than 1 cycle after acceptance; wb_pipe_valid the cycle after dbus_rvalid.
- Exactly one bus transaction is outstanding at most.
- dbus_addr, dbus_wdata, dbus_byte_enable and dbus_write are stable while dbus_req=1 and ~dbus_ready.
- wb_trap and dbus_ready in the same cycle: wb_trap wins; dbus_req=0, so no acceptance.
- Reset asserted mid-transaction returns to IDLE immediately; a later stray dbus_rvalid is ignored in IDLE.

## Structure
- Shared core package or header: funct3 load/store constants, exception codes (4, 6), and the state enum for this block.
- Sub-module mem_lsu_align: combinational store lane/byte-enable generation and load extraction/extension.
- The FSM, hold register and output register live in mem_stage.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF, dbus_ready=1 in the same cycle -> dbus_addr=0x104, byte_enable=1111; wb_pipe_valid next cycle.
- LB addr 0x103, rdata 0x80FF_0000, rvalid 3 cycles after accept -> rd_data=0xFFFFFF80; LBU -> 0x00000080.
- SH addr 0x102, wdata 0x1234 -> byte_enable=1100, wdata=0x12341234; dbus_ready delayed 2 cycles -> request held stable.
- LW addr 0x101 -> no dbus_req; wb_pipe_exc_pending=1, exc_code=4, exc_tval=0x101.
- LW accepted, then wb_trap while in WAIT -> DRAIN; rvalid discarded; wb_pipe_valid stays 0; next instruction proceeds.
- Store in REQ with wb_trap=1 and dbus_ready=1 in the same cycle -> dbus_req=0, no write; reset mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-width encodings,
// misaligned-access exception codes and the stage's state encoding.
package mem_stage_pkg;

   localparam int XLEN       = 32;
   localparam int CSR_INFO_W = 3;
   localparam int EXC_CODE_W = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [EXC_CODE_W-1:0] EXC_LOAD_MISALIGNED  = 4'd4;
   localparam logic [EXC_CODE_W-1:0] EXC_STORE_MISALIGNED = 4'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DRAIN
   } mem_state_t;

   // Halfwords need an even address, words a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
      case (width)
         2'b01:   return addr_lo[0];
         2'b10:   return (addr_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the data bus: store replication/byte enables and
// load lane extraction with sign or zero extension.
module mem_lsu_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] store_lanes,
   output logic [3:0]      byte_enable,
   output logic [XLEN-1:0] load_result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      store_lanes = store_data;
      byte_enable = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            store_lanes = {4{store_data[7:0]}};
            byte_enable = 4'b0001 << addr_lo;
         end
         2'b01: begin
            store_lanes = {2{store_data[15:0]}};
            byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel    = load_data[{addr_lo, 3'b000} +: 8];
      half_sel    = addr_lo[1] ? load_data[31:16] : load_data[15:0];
      load_result = load_data;
      case (funct3)
         F3_B:    load_result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_result = {24'h000000, byte_sel};
         F3_H:    load_result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_result = {16'h0000, half_sel};
         default: load_result = load_data;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: issues loads/stores on the data bus, formats results and
// registers them onto the MEM->WB interface; a WB trap kills the entry.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter bit SUPPORT_TRAP = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_b,
   output logic                  mem_pipe_ready,
   output logic                  mem_pipe_flush,
   input  logic                  mem_pipe_valid,
   input  logic [XLEN-1:0]       mem_pipe_pc,
   input  logic [31:0]           mem_pipe_instruction,
   input  logic                  mem_pipe_rd_write,
   input  logic [4:0]            mem_pipe_rd_addr,
   input  logic                  mem_pipe_csr_write,
   input  logic                  mem_pipe_csr_set,
   input  logic                  mem_pipe_csr_clear,
   input  logic                  mem_pipe_csr_read,
   input  logic [CSR_INFO_W-1:0] mem_pipe_csr_info,
   input  logic [11:0]           mem_pipe_csr_addr,
   input  logic                  mem_pipe_mret,
   input  logic                  mem_pipe_exc_pending,
   input  logic [EXC_CODE_W-1:0] mem_pipe_exc_code,
   input  logic [XLEN-1:0]       mem_pipe_exc_tval,
   input  logic                  mem_pipe_exc_interrupt,
   input  logic [XLEN-1:0]       mem_pipe_rd_data,
   input  logic                  mem_pipe_mem_read,
   input  logic                  mem_pipe_mem_write,
   input  logic [2:0]            mem_pipe_mem_funct3,
   input  logic [XLEN-1:0]       mem_pipe_mem_wdata,
   output logic                  dbus_req,
   output logic                  dbus_write,
   output logic [XLEN-1:0]       dbus_addr,
   output logic [XLEN-1:0]       dbus_wdata,
   output logic [3:0]            dbus_byte_enable,
   input  logic                  dbus_ready,
   input  logic                  dbus_rvalid,
   input  logic [XLEN-1:0]       dbus_rdata,
   input  logic                  wb_pipe_ready,
   input  logic                  wb_trap,
   output logic                  wb_pipe_valid,
   output logic [XLEN-1:0]       wb_pipe_pc,
   output logic [31:0]           wb_pipe_instruction,
   output logic                  wb_pipe_rd_write,
   output logic [4:0]            wb_pipe_rd_addr,
   output logic [XLEN-1:0]       wb_pipe_rd_data,
   output logic                  wb_pipe_csr_write,
   output logic                  wb_pipe_csr_set,
   output logic                  wb_pipe_csr_clear,
   output logic                  wb_pipe_csr_read,
   output logic [CSR_INFO_W-1:0] wb_pipe_csr_info,
   output logic [11:0]           wb_pipe_csr_addr,
   output logic                  wb_pipe_mret,
   output logic                  wb_pipe_exc_pending,
   output logic [EXC_CODE_W-1:0] wb_pipe_exc_code,
   output logic [XLEN-1:0]       wb_pipe_exc_tval,
   output logic                  wb_pipe_exc_interrupt
);

   mem_state_t state;

   logic                  misaligned;
   logic                  mem_op;
   logic                  out_free;
   logic                  done;
   logic [XLEN-1:0]       hold_data;
   logic [XLEN-1:0]       load_result;
   logic [XLEN-1:0]       out_rd_data;
   logic                  out_exc_pending;
   logic [EXC_CODE_W-1:0] out_exc_code;
   logic [XLEN-1:0]       out_exc_tval;
   logic                  out_exc_interrupt;

   mem_lsu_align u_align (
      .addr_lo     (mem_pipe_rd_data[1:0]),
      .funct3      (mem_pipe_mem_funct3),
      .store_data  (mem_pipe_mem_wdata),
      .load_data   (dbus_rdata),
      .store_lanes (dbus_wdata),
      .byte_enable (dbus_byte_enable),
      .load_result (load_result)
   );

   assign misaligned = SUPPORT_TRAP && (mem_pipe_mem_read || mem_pipe_mem_write) &&
                       is_misaligned(mem_pipe_mem_funct3[1:0], mem_pipe_rd_data[1:0]);
   assign mem_op     = mem_pipe_valid & (mem_pipe_mem_read | mem_pipe_mem_write) &
                       ~mem_pipe_exc_pending & ~misaligned;
   assign out_free   = ~wb_pipe_valid | wb_pipe_ready;

   // EX holds its entry until mem_pipe_ready, so the bus request is stable in REQ.
   assign dbus_req       = ~wb_trap & (((state == ST_IDLE) & mem_op) | (state == ST_REQ));
   assign dbus_write     = mem_pipe_mem_write;
   assign dbus_addr      = {mem_pipe_rd_data[XLEN-1:2], 2'b00};
   assign mem_pipe_ready = done & out_free & ~wb_trap;
   assign mem_pipe_flush = wb_trap;

   always_comb begin
      done = 1'b0;
      case (state)
         ST_IDLE: done = mem_pipe_valid & (~mem_op | (mem_pipe_mem_write & dbus_ready));
         ST_REQ:  done = mem_pipe_mem_write & dbus_ready;
         ST_WAIT: done = dbus_rvalid;
         ST_HOLD: done = 1'b1;
         default: done = 1'b0;
      endcase
   end

   always_comb begin
      out_rd_data       = mem_pipe_rd_data;
      out_exc_pending   = mem_pipe_exc_pending;
      out_exc_code      = mem_pipe_exc_code;
      out_exc_tval      = mem_pipe_exc_tval;
      out_exc_interrupt = mem_pipe_exc_interrupt;
      if (state == ST_WAIT) begin
         out_rd_data = load_result;
      end else if (state == ST_HOLD) begin
         out_rd_data = hold_data;
      end
      if (~mem_pipe_exc_pending & misaligned) begin
         out_exc_pending   = 1'b1;
         out_exc_code      = mem_pipe_mem_write ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
         out_exc_tval      = mem_pipe_rd_data;
         out_exc_interrupt = 1'b0;
      end
   end

   // An accepted access whose result cannot enter a busy output register parks in HOLD.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state                 <= ST_IDLE;
         hold_data             <= '0;
         wb_pipe_valid         <= 1'b0;
         wb_pipe_pc            <= '0;
         wb_pipe_instruction   <= '0;
         wb_pipe_rd_write      <= 1'b0;
         wb_pipe_rd_addr       <= '0;
         wb_pipe_rd_data       <= '0;
         wb_pipe_csr_write     <= 1'b0;
         wb_pipe_csr_set       <= 1'b0;
         wb_pipe_csr_clear     <= 1'b0;
         wb_pipe_csr_read      <= 1'b0;
         wb_pipe_csr_info      <= '0;
         wb_pipe_csr_addr      <= '0;
         wb_pipe_mret          <= 1'b0;
         wb_pipe_exc_pending   <= 1'b0;
         wb_pipe_exc_code      <= '0;
         wb_pipe_exc_tval      <= '0;
         wb_pipe_exc_interrupt <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (~wb_trap & mem_op) begin
                  if (~dbus_ready) begin
                     state <= ST_REQ;
                  end else if (~mem_pipe_mem_write) begin
                     state <= ST_WAIT;
                  end else if (~out_free) begin
                     hold_data <= mem_pipe_rd_data;
                     state     <= ST_HOLD;
                  end
               end
            end
            ST_REQ: begin
               if (wb_trap) begin
                  state <= ST_IDLE;
               end else if (dbus_ready) begin
                  if (~mem_pipe_mem_write) begin
                     state <= ST_WAIT;
                  end else if (out_free) begin
                     state <= ST_IDLE;
                  end else begin
                     hold_data <= mem_pipe_rd_data;
                     state     <= ST_HOLD;
                  end
               end
            end
            ST_WAIT: begin
               if (dbus_rvalid) begin
                  if (wb_trap | out_free) begin
                     state <= ST_IDLE;
                  end else begin
                     hold_data <= load_result;
                     state     <= ST_HOLD;
                  end
               end else if (wb_trap) begin
                  state <= ST_DRAIN;
               end
            end
            ST_HOLD: begin
               if (wb_trap | out_free) begin
                  state <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (dbus_rvalid) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (wb_trap) begin
            wb_pipe_valid <= 1'b0;
         end else if (mem_pipe_ready) begin
            wb_pipe_valid         <= 1'b1;
            wb_pipe_pc            <= mem_pipe_pc;
            wb_pipe_instruction   <= mem_pipe_instruction;
            wb_pipe_rd_write      <= mem_pipe_rd_write;
            wb_pipe_rd_addr       <= mem_pipe_rd_addr;
            wb_pipe_rd_data       <= out_rd_data;
            wb_pipe_csr_write     <= mem_pipe_csr_write;
            wb_pipe_csr_set       <= mem_pipe_csr_set;
            wb_pipe_csr_clear     <= mem_pipe_csr_clear;
            wb_pipe_csr_read      <= mem_pipe_csr_read;
            wb_pipe_csr_info      <= mem_pipe_csr_info;
            wb_pipe_csr_addr      <= mem_pipe_csr_addr;
            wb_pipe_mret          <= mem_pipe_mret;
            wb_pipe_exc_pending   <= out_exc_pending;
            wb_pipe_exc_code      <= out_exc_code;
            wb_pipe_exc_tval      <= out_exc_tval;
            wb_pipe_exc_interrupt <= out_exc_interrupt;
         end else if (wb_pipe_ready) begin
            wb_pipe_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, misalignment, trap kill/drain,
// hold path and asynchronous reset, with hand-computed expectations.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                  clk;
   logic                  rst_b;
   logic                  mem_pipe_ready;
   logic                  mem_pipe_flush;
   logic                  mem_pipe_valid;
   logic [XLEN-1:0]       mem_pipe_pc;
   logic [31:0]           mem_pipe_instruction;
   logic                  mem_pipe_rd_write;
   logic [4:0]            mem_pipe_rd_addr;
   logic                  mem_pipe_csr_write;
   logic                  mem_pipe_csr_set;
   logic                  mem_pipe_csr_clear;
   logic                  mem_pipe_csr_read;
   logic [CSR_INFO_W-1:0] mem_pipe_csr_info;
   logic [11:0]           mem_pipe_csr_addr;
   logic                  mem_pipe_mret;
   logic                  mem_pipe_exc_pending;
   logic [EXC_CODE_W-1:0] mem_pipe_exc_code;
   logic [XLEN-1:0]       mem_pipe_exc_tval;
   logic                  mem_pipe_exc_interrupt;
   logic [XLEN-1:0]       mem_pipe_rd_data;
   logic                  mem_pipe_mem_read;
   logic                  mem_pipe_mem_write;
   logic [2:0]            mem_pipe_mem_funct3;
   logic [XLEN-1:0]       mem_pipe_mem_wdata;
   logic                  dbus_req;
   logic                  dbus_write;
   logic [XLEN-1:0]       dbus_addr;
   logic [XLEN-1:0]       dbus_wdata;
   logic [3:0]            dbus_byte_enable;
   logic                  dbus_ready;
   logic                  dbus_rvalid;
   logic [XLEN-1:0]       dbus_rdata;
   logic                  wb_pipe_ready;
   logic                  wb_trap;
   logic                  wb_pipe_valid;
   logic [XLEN-1:0]       wb_pipe_pc;
   logic [31:0]           wb_pipe_instruction;
   logic                  wb_pipe_rd_write;
   logic [4:0]            wb_pipe_rd_addr;
   logic [XLEN-1:0]       wb_pipe_rd_data;
   logic                  wb_pipe_csr_write;
   logic                  wb_pipe_csr_set;
   logic                  wb_pipe_csr_clear;
   logic                  wb_pipe_csr_read;
   logic [CSR_INFO_W-1:0] wb_pipe_csr_info;
   logic [11:0]           wb_pipe_csr_addr;
   logic                  wb_pipe_mret;
   logic                  wb_pipe_exc_pending;
   logic [EXC_CODE_W-1:0] wb_pipe_exc_code;
   logic [XLEN-1:0]       wb_pipe_exc_tval;
   logic                  wb_pipe_exc_interrupt;

   int compared   = 0;
   int mismatched = 0;

   mem_stage #(.SUPPORT_TRAP(1'b1)) dut (
      .clk                    (clk),
      .rst_b                  (rst_b),
      .mem_pipe_ready         (mem_pipe_ready),
      .mem_pipe_flush         (mem_pipe_flush),
      .mem_pipe_valid         (mem_pipe_valid),
      .mem_pipe_pc            (mem_pipe_pc),
      .mem_pipe_instruction   (mem_pipe_instruction),
      .mem_pipe_rd_write      (mem_pipe_rd_write),
      .mem_pipe_rd_addr       (mem_pipe_rd_addr),
      .mem_pipe_csr_write     (mem_pipe_csr_write),
      .mem_pipe_csr_set       (mem_pipe_csr_set),
      .mem_pipe_csr_clear     (mem_pipe_csr_clear),
      .mem_pipe_csr_read      (mem_pipe_csr_read),
      .mem_pipe_csr_info      (mem_pipe_csr_info),
      .mem_pipe_csr_addr      (mem_pipe_csr_addr),
      .mem_pipe_mret          (mem_pipe_mret),
      .mem_pipe_exc_pending   (mem_pipe_exc_pending),
      .mem_pipe_exc_code      (mem_pipe_exc_code),
      .mem_pipe_exc_tval      (mem_pipe_exc_tval),
      .mem_pipe_exc_interrupt (mem_pipe_exc_interrupt),
      .mem_pipe_rd_data       (mem_pipe_rd_data),
      .mem_pipe_mem_read      (mem_pipe_mem_read),
      .mem_pipe_mem_write     (mem_pipe_mem_write),
      .mem_pipe_mem_funct3    (mem_pipe_mem_funct3),
      .mem_pipe_mem_wdata     (mem_pipe_mem_wdata),
      .dbus_req               (dbus_req),
      .dbus_write             (dbus_write),
      .dbus_addr              (dbus_addr),
      .dbus_wdata             (dbus_wdata),
      .dbus_byte_enable       (dbus_byte_enable),
      .dbus_ready             (dbus_ready),
      .dbus_rvalid            (dbus_rvalid),
      .dbus_rdata             (dbus_rdata),
      .wb_pipe_ready          (wb_pipe_ready),
      .wb_trap                (wb_trap),
      .wb_pipe_valid          (wb_pipe_valid),
      .wb_pipe_pc             (wb_pipe_pc),
      .wb_pipe_instruction    (wb_pipe_instruction),
      .wb_pipe_rd_write       (wb_pipe_rd_write),
      .wb_pipe_rd_addr        (wb_pipe_rd_addr),
      .wb_pipe_rd_data        (wb_pipe_rd_data),
      .wb_pipe_csr_write      (wb_pipe_csr_write),
      .wb_pipe_csr_set        (wb_pipe_csr_set),
      .wb_pipe_csr_clear      (wb_pipe_csr_clear),
      .wb_pipe_csr_read       (wb_pipe_csr_read),
      .wb_pipe_csr_info       (wb_pipe_csr_info),
      .wb_pipe_csr_addr       (wb_pipe_csr_addr),
      .wb_pipe_mret           (wb_pipe_mret),
      .wb_pipe_exc_pending    (wb_pipe_exc_pending),
      .wb_pipe_exc_code       (wb_pipe_exc_code),
      .wb_pipe_exc_tval       (wb_pipe_exc_tval),
      .wb_pipe_exc_interrupt  (wb_pipe_exc_interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout required $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic clear_entry();
      mem_pipe_valid         = 1'b0;
      mem_pipe_pc            = '0;
      mem_pipe_instruction   = '0;
      mem_pipe_rd_write      = 1'b0;
      mem_pipe_rd_addr       = '0;
      mem_pipe_csr_write     = 1'b0;
      mem_pipe_csr_set       = 1'b0;
      mem_pipe_csr_clear     = 1'b0;
      mem_pipe_csr_read      = 1'b0;
      mem_pipe_csr_info      = '0;
      mem_pipe_csr_addr      = '0;
      mem_pipe_mret          = 1'b0;
      mem_pipe_exc_pending   = 1'b0;
      mem_pipe_exc_code      = '0;
      mem_pipe_exc_tval      = '0;
      mem_pipe_exc_interrupt = 1'b0;
      mem_pipe_rd_data       = '0;
      mem_pipe_mem_read      = 1'b0;
      mem_pipe_mem_write     = 1'b0;
      mem_pipe_mem_funct3    = '0;
      mem_pipe_mem_wdata     = '0;
   endtask

   task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
      mem_pipe_valid      = 1'b1;
      mem_pipe_mem_read   = rd;
      mem_pipe_mem_write  = wr;
      mem_pipe_mem_funct3 = f3;
      mem_pipe_rd_data    = addr;
      mem_pipe_mem_wdata  = wdata;
      mem_pipe_pc         = pc;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_entry();
      rst_b         = 1'b1;
      dbus_ready    = 1'b0;
      dbus_rvalid   = 1'b0;
      dbus_rdata    = '0;
      wb_pipe_ready = 1'b1;
      wb_trap       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_wb_valid", 32'(wb_pipe_valid), 32'd0);
      check_output("reset_wb_pc", wb_pipe_pc, 32'h0);
      check_output("reset_wb_rd_data", wb_pipe_rd_data, 32'h0);
      check_output("reset_dbus_req", 32'(dbus_req), 32'd0);
      rst_b = 1'b0;
      next_cycle();

      // SW 0x104 accepted in the same cycle
      apply_stimulus(1'b0, 1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'h40);
      dbus_ready = 1'b1;
      #1;
      check_output("sw_req", 32'(dbus_req), 32'd1);
      check_output("sw_write", 32'(dbus_write), 32'd1);
      check_output("sw_addr", dbus_addr, 32'h104);
      check_output("sw_be", 32'(dbus_byte_enable), 32'hF);
      check_output("sw_wdata", dbus_wdata, 32'hDEADBEEF);
      check_output("sw_ready", 32'(mem_pipe_ready), 32'd1);
      next_cycle();
      check_output("sw_wb_valid", 32'(wb_pipe_valid), 32'd1);
      check_output("sw_wb_pc", wb_pipe_pc, 32'h40);
      clear_entry();
      dbus_ready = 1'b0;

      // LB 0x103, response three cycles after acceptance
      apply_stimulus(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h44);
      mem_pipe_rd_write = 1'b1;
      mem_pipe_rd_addr  = 5'd5;
      dbus_ready = 1'b1;
      #1;
      check_output("lb_req", 32'(dbus_req), 32'd1);
      check_output("lb_addr", dbus_addr, 32'h100);
      check_output("lb_ready_early", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      dbus_ready = 1'b0;
      #1;
      check_output("lb_wait_req", 32'(dbus_req), 32'd0);
      check_output("lb_wb_idle", 32'(wb_pipe_valid), 32'd0);
      next_cycle();
      next_cycle();
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h80FF0000;
      #1;
      check_output("lb_rvalid_ready", 32'(mem_pipe_ready), 32'd1);
      next_cycle();
      dbus_rvalid = 1'b0;
      check_output("lb_wb_valid", 32'(wb_pipe_valid), 32'd1);
      check_output("lb_data", wb_pipe_rd_data, 32'hFFFFFF80);
      check_output("lb_rd_addr", 32'(wb_pipe_rd_addr), 32'd5);
      clear_entry();

      // LBU 0x103, response one cycle after acceptance
      apply_stimulus(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h48);
      dbus_ready = 1'b1;
      next_cycle();
      dbus_ready  = 1'b0;
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h80FF0000;
      next_cycle();
      dbus_rvalid = 1'b0;
      check_output("lbu_data", wb_pipe_rd_data, 32'h00000080);
      check_output("lbu_pc", wb_pipe_pc, 32'h48);
      clear_entry();

      // SH 0x102 with bus acceptance delayed two cycles
      apply_stimulus(1'b0, 1'b1, F3_H, 32'h102, 32'h00001234, 32'h50);
      #1;
      check_output("sh_req", 32'(dbus_req), 32'd1);
      check_output("sh_be", 32'(dbus_byte_enable), 32'hC);
      check_output("sh_wdata", dbus_wdata, 32'h12341234);
      check_output("sh_addr", dbus_addr, 32'h100);
      check_output("sh_ready_wait", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      check_output("sh_req_hold", 32'(dbus_req), 32'd1);
      check_output("sh_be_hold", 32'(dbus_byte_enable), 32'hC);
      check_output("sh_wdata_hold", dbus_wdata, 32'h12341234);
      check_output("sh_ready_hold", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      dbus_ready = 1'b1;
      #1;
      check_output("sh_accept_ready", 32'(mem_pipe_ready), 32'd1);
      next_cycle();
      check_output("sh_wb_valid", 32'(wb_pipe_valid), 32'd1);
      check_output("sh_wb_pc", wb_pipe_pc, 32'h50);
      clear_entry();
      dbus_ready = 1'b0;

      // Misaligned LW 0x101 and SW 0x102
      apply_stimulus(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 32'h60);
      #1;
      check_output("lw_mis_req", 32'(dbus_req), 32'd0);
      check_output("lw_mis_ready", 32'(mem_pipe_ready), 32'd1);
      next_cycle();
      check_output("lw_mis_valid", 32'(wb_pipe_valid), 32'd1);
      check_output("lw_mis_pending", 32'(wb_pipe_exc_pending), 32'd1);
      check_output("lw_mis_code", 32'(wb_pipe_exc_code), 32'd4);
      check_output("lw_mis_tval", wb_pipe_exc_tval, 32'h101);
      apply_stimulus(1'b0, 1'b1, F3_W, 32'h102, 32'h55, 32'h64);
      #1;
      check_output("sw_mis_req", 32'(dbus_req), 32'd0);
      next_cycle();
      check_output("sw_mis_code", 32'(wb_pipe_exc_code), 32'd6);
      check_output("sw_mis_tval", wb_pipe_exc_tval, 32'h102);
      clear_entry();

      // LW accepted, trap in WAIT, response drained
      apply_stimulus(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'h70);
      dbus_ready = 1'b1;
      next_cycle();
      dbus_ready = 1'b0;
      wb_trap    = 1'b1;
      #1;
      check_output("trap_req", 32'(dbus_req), 32'd0);
      check_output("trap_flush", 32'(mem_pipe_flush), 32'd1);
      check_output("trap_ready", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      wb_trap = 1'b0;
      clear_entry();
      apply_stimulus(1'b0, 1'b0, F3_W, 32'h12345678, 32'h0, 32'h300);
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'hCAFEF00D;
      #1;
      check_output("drain_ready", 32'(mem_pipe_ready), 32'd0);
      check_output("drain_wb_valid", 32'(wb_pipe_valid), 32'd0);
      next_cycle();
      dbus_rvalid = 1'b0;
      check_output("drain_exit_wb_valid", 32'(wb_pipe_valid), 32'd0);
      #1;
      check_output("next_ready", 32'(mem_pipe_ready), 32'd1);
      check_output("next_req", 32'(dbus_req), 32'd0);
      next_cycle();
      check_output("next_wb_valid", 32'(wb_pipe_valid), 32'd1);
      check_output("next_wb_pc", wb_pipe_pc, 32'h300);
      check_output("next_wb_rd_data", wb_pipe_rd_data, 32'h12345678);
      clear_entry();

      // Store in REQ killed by a trap that coincides with dbus_ready
      apply_stimulus(1'b0, 1'b1, F3_W, 32'h108, 32'hA5A5A5A5, 32'h80);
      next_cycle();
      wb_trap    = 1'b1;
      dbus_ready = 1'b1;
      #1;
      check_output("req_trap_req", 32'(dbus_req), 32'd0);
      check_output("req_trap_ready", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      wb_trap    = 1'b0;
      dbus_ready = 1'b0;
      clear_entry();
      #1;
      check_output("req_trap_wb_valid", 32'(wb_pipe_valid), 32'd0);
      check_output("req_trap_idle_req", 32'(dbus_req), 32'd0);

      // Load result parked in HOLD while WB is stalled
      apply_stimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'h500);
      next_cycle();
      wb_pipe_ready = 1'b0;
      check_output("hold_prev_valid", 32'(wb_pipe_valid), 32'd1);
      apply_stimulus(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h90);
      dbus_ready = 1'b1;
      #1;
      check_output("lh_req", 32'(dbus_req), 32'd1);
      next_cycle();
      dbus_ready  = 1'b0;
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h80017FFF;
      #1;
      check_output("lh_blocked_ready", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      dbus_rvalid = 1'b0;
      dbus_rdata  = 32'h0;
      check_output("hold_keep_pc", wb_pipe_pc, 32'h500);
      wb_pipe_ready = 1'b1;
      #1;
      check_output("hold_ready", 32'(mem_pipe_ready), 32'd1);
      next_cycle();
      check_output("lh_data", wb_pipe_rd_data, 32'hFFFF8001);
      check_output("lh_pc", wb_pipe_pc, 32'h90);
      clear_entry();

      // Asynchronous reset in WAIT, then a stray response in IDLE
      wb_pipe_ready = 1'b0;
      apply_stimulus(1'b1, 1'b0, F3_W, 32'h10C, 32'h0, 32'hA0);
      dbus_ready = 1'b1;
      next_cycle();
      clear_entry();
      dbus_ready = 1'b0;
      rst_b      = 1'b1;
      #1;
      check_output("rst_wb_valid", 32'(wb_pipe_valid), 32'd0);
      check_output("rst_wb_pc", wb_pipe_pc, 32'h0);
      check_output("rst_wb_rd_data", wb_pipe_rd_data, 32'h0);
      check_output("rst_dbus_req", 32'(dbus_req), 32'd0);
      check_output("rst_ready", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      rst_b         = 1'b0;
      wb_pipe_ready = 1'b1;
      dbus_rvalid   = 1'b1;
      dbus_rdata    = 32'hFFFFFFFF;
      #1;
      check_output("stray_ready", 32'(mem_pipe_ready), 32'd0);
      next_cycle();
      dbus_rvalid = 1'b0;
      check_output("stray_wb_valid", 32'(wb_pipe_valid), 32'd0);
      apply_stimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'hB0);
      #1;
      check_output("post_reset_ready", 32'(mem_pipe_ready), 32'd1);
      next_cycle();
      check_output("post_reset_pc", wb_pipe_pc, 32'hB0);
      clear_entry();
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
